// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU replacement,
// registered lookup/refill responses, miss victim reporting and a flush
// engine that streams dirty lines out over a valid/ready handshake.
module dcache_sram_nway #(
    parameter int WAYS      = 2,
    parameter int SET_BITS  = 4,
    parameter int TAG_BITS  = 23,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [SET_BITS-1:0]  addr_i,
    input  logic [TAG_BITS+1:0]  tag_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic [TAG_BITS+1:0]  tag_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 hit_o,
    output logic                 resp_o,
    input  logic                 flush_req_i,
    input  logic                 flush_inv_i,
    output logic                 busy_o,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [SET_BITS-1:0]  wb_set_o,
    output logic [TAG_BITS-1:0]  wb_tag_o,
    output logic [LINE_BITS-1:0] wb_data_o,
    output logic                 flush_done_o
);
    localparam int SETS     = 2**SET_BITS;
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int IDX_BITS = SET_BITS + WAY_BITS;
    localparam logic [WAY_BITS-1:0] OLDEST = WAY_BITS'(WAYS-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Storage: one entry per (set, way); age 0 = most recently used
    logic                 valid_r    [SETS][WAYS];
    logic                 dirty_r    [SETS][WAYS];
    logic [TAG_BITS-1:0]  tag_mem_r  [SETS][WAYS];
    logic [LINE_BITS-1:0] data_mem_r [SETS][WAYS];
    logic [WAY_BITS-1:0]  age_r      [SETS][WAYS];

    // Response and flush registers
    logic [TAG_BITS+1:0]  tag_out_r;
    logic [LINE_BITS-1:0] data_out_r;
    logic                 hit_r;
    logic                 resp_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 wb_valid_r;
    logic [SET_BITS-1:0]  wb_set_r;
    logic [TAG_BITS-1:0]  wb_tag_r;
    logic [LINE_BITS-1:0] wb_data_r;
    logic [IDX_BITS-1:0]  scan_idx_r;
    logic                 inv_r;
    state_t               state_r;
    state_t               state_s;

    // Access-path combinational signals
    logic                 access_s;
    logic                 wr_s;
    logic                 touch_s;
    logic                 hit_s;
    logic                 any_inv_s;
    logic [WAY_BITS-1:0]  hit_way_s;
    logic [WAY_BITS-1:0]  inv_way_s;
    logic [WAY_BITS-1:0]  lru_way_s;
    logic [WAY_BITS-1:0]  victim_way_s;
    logic [WAY_BITS-1:0]  sel_way_s;
    logic [WAY_BITS-1:0]  old_age_s;
    logic [WAY_BITS-1:0]  new_age_s [WAYS];

    // Flush-path combinational signals
    logic [SET_BITS-1:0]  scan_set_s;
    logic [WAY_BITS-1:0]  scan_way_s;
    logic                 scan_dirty_s;
    logic                 scan_last_s;
    logic                 advance_s;
    logic                 load_wb_s;
    logic                 clear_s;

    // A write always stores valid=1, so the incoming valid bit carries no information
    logic unused_s;
    assign unused_s = tag_i[TAG_BITS+1];

    // Accesses are only accepted while the flush engine is idle
    assign access_s = enable_i & ~busy_r;
    assign wr_s     = access_s & write_i;

    // Tag compare plus free-way and LRU-way search in the addressed set
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        any_inv_s = 1'b0;
        inv_way_s = '0;
        lru_way_s = '0;
        // Descending scan so the lowest-index free way wins
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!valid_r[addr_i][w]) begin
                any_inv_s = 1'b1;
                inv_way_s = WAY_BITS'(w);
            end else if (tag_mem_r[addr_i][w] == tag_i[TAG_BITS-1:0]) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_BITS'(w);
            end else begin
                // valid way with a different tag: neither hit nor free
            end
            lru_way_s = (age_r[addr_i][w] == OLDEST) ? WAY_BITS'(w) : lru_way_s;
        end
    end

    assign victim_way_s = any_inv_s ? inv_way_s : lru_way_s;
    assign sel_way_s    = hit_s ? hit_way_s : victim_way_s;
    assign touch_s      = access_s & (hit_s | write_i);
    assign old_age_s    = age_r[addr_i][sel_way_s];

    // True-LRU touch: selected way becomes youngest, younger ways age by one
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_BITS'(w) == sel_way_s) begin
                new_age_s[w] = '0;
            end else if (age_r[addr_i][w] < old_age_s) begin
                new_age_s[w] = age_r[addr_i][w] + WAY_BITS'(1);
            end else begin
                new_age_s[w] = age_r[addr_i][w];
            end
        end
    end

    // Flush scan position: way-major within a set, sets ascending
    assign scan_set_s   = scan_idx_r[IDX_BITS-1:WAY_BITS];
    assign scan_way_s   = scan_idx_r[WAY_BITS-1:0];
    assign scan_dirty_s = valid_r[scan_set_s][scan_way_s] & dirty_r[scan_set_s][scan_way_s];
    assign scan_last_s  = &scan_idx_r;

    // Flush FSM next state and per-cycle control strobes
    always_comb begin
        state_s   = state_r;
        advance_s = 1'b0;
        load_wb_s = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_dirty_s) begin
                    load_wb_s = 1'b1;
                    state_s   = ST_EMIT;
                end else begin
                    advance_s = 1'b1;
                    state_s   = scan_last_s ? ST_DONE : ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (wb_ready_i) begin
                    clear_s   = 1'b1;
                    advance_s = 1'b1;
                    state_s   = scan_last_s ? ST_DONE : ST_SCAN;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Flush FSM state, scan pointer and registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            scan_idx_r <= '0;
            inv_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_set_r   <= '0;
            wb_tag_r   <= '0;
            wb_data_r  <= '0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
            wb_valid_r <= (state_s == ST_EMIT);
            if ((state_r == ST_IDLE) && flush_req_i) begin
                scan_idx_r <= '0;
                inv_r      <= flush_inv_i;
            end else if (advance_s) begin
                scan_idx_r <= scan_idx_r + IDX_BITS'(1);
            end
            if (load_wb_s) begin
                wb_set_r  <= scan_set_s;
                wb_tag_r  <= tag_mem_r[scan_set_s][scan_way_s];
                wb_data_r <= data_mem_r[scan_set_s][scan_way_s];
            end
        end
    end

    // Registered access response; holds until the next accepted access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resp_r     <= 1'b0;
            hit_r      <= 1'b0;
            tag_out_r  <= '0;
            data_out_r <= '0;
        end else begin
            resp_r <= access_s;
            if (access_s) begin
                hit_r <= hit_s;
                if (wr_s && hit_s) begin
                    tag_out_r  <= {1'b1, tag_i[TAG_BITS], tag_i[TAG_BITS-1:0]};
                    data_out_r <= data_i;
                end else begin
                    tag_out_r  <= {valid_r[addr_i][sel_way_s], dirty_r[addr_i][sel_way_s],
                                   tag_mem_r[addr_i][sel_way_s]};
                    data_out_r <= data_mem_r[addr_i][sel_way_s];
                end
            end
        end
    end

    // Storage array updates from accesses (idle only) and the flush engine
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w]    <= 1'b0;
                    dirty_r[s][w]    <= 1'b0;
                    tag_mem_r[s][w]  <= '0;
                    data_mem_r[s][w] <= '0;
                    age_r[s][w]      <= WAY_BITS'(w);
                end
            end
        end else begin
            if (wr_s) begin
                valid_r[addr_i][sel_way_s]    <= 1'b1;
                dirty_r[addr_i][sel_way_s]    <= tag_i[TAG_BITS];
                tag_mem_r[addr_i][sel_way_s]  <= tag_i[TAG_BITS-1:0];
                data_mem_r[addr_i][sel_way_s] <= data_i;
            end
            if (touch_s) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_r[addr_i][w] <= new_age_s[w];
                end
            end
            if (clear_s) begin
                dirty_r[scan_set_s][scan_way_s] <= 1'b0;
            end
            if (inv_r && advance_s) begin
                valid_r[scan_set_s][scan_way_s] <= 1'b0;
                dirty_r[scan_set_s][scan_way_s] <= 1'b0;
            end
        end
    end

    assign tag_o        = tag_out_r;
    assign data_o       = data_out_r;
    assign hit_o        = hit_r;
    assign resp_o       = resp_r;
    assign busy_o       = busy_r;
    assign wb_valid_o   = wb_valid_r;
    assign wb_set_o     = wb_set_r;
    assign wb_tag_o     = wb_tag_r;
    assign wb_data_o    = wb_data_r;
    assign flush_done_o = done_r;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway (4-way configuration).
module tb_dcache_sram_nway;
    localparam int WAYS      = 4;
    localparam int SET_BITS  = 4;
    localparam int TAG_BITS  = 23;
    localparam int LINE_BITS = 256;

    localparam logic [TAG_BITS-1:0] TA = 23'h00000A;
    localparam logic [TAG_BITS-1:0] TB = 23'h00000B;
    localparam logic [TAG_BITS-1:0] TC = 23'h00000C;
    localparam logic [TAG_BITS-1:0] TD = 23'h00000D;
    localparam logic [TAG_BITS-1:0] TE = 23'h00000E;
    localparam logic [TAG_BITS-1:0] TF = 23'h00000F;
    localparam logic [TAG_BITS-1:0] TX = 23'h000100;
    localparam logic [TAG_BITS-1:0] T1 = 23'h000111;
    localparam logic [TAG_BITS-1:0] T2 = 23'h000222;
    localparam logic [TAG_BITS-1:0] T3 = 23'h000333;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 enable_i = 1'b0;
    logic                 write_i = 1'b0;
    logic [SET_BITS-1:0]  addr_i = '0;
    logic [TAG_BITS+1:0]  tag_i = '0;
    logic [LINE_BITS-1:0] data_i = '0;
    logic [TAG_BITS+1:0]  tag_o;
    logic [LINE_BITS-1:0] data_o;
    logic                 hit_o;
    logic                 resp_o;
    logic                 flush_req_i = 1'b0;
    logic                 flush_inv_i = 1'b0;
    logic                 busy_o;
    logic                 wb_valid_o;
    logic                 wb_ready_i = 1'b0;
    logic [SET_BITS-1:0]  wb_set_o;
    logic [TAG_BITS-1:0]  wb_tag_o;
    logic [LINE_BITS-1:0] wb_data_o;
    logic                 flush_done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_sram_nway #(
        .WAYS(WAYS), .SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS), .LINE_BITS(LINE_BITS)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i), .tag_o(tag_o),
        .data_o(data_o), .hit_o(hit_o), .resp_o(resp_o),
        .flush_req_i(flush_req_i), .flush_inv_i(flush_inv_i), .busy_o(busy_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o),
        .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o), .flush_done_o(flush_done_o)
    );

    function automatic logic [LINE_BITS-1:0] line(input logic [31:0] w);
        return {8{w}};
    endfunction

    function automatic logic [TAG_BITS+1:0] ent(input logic v, input logic d,
                                                input logic [TAG_BITS-1:0] t);
        return {v, d, t};
    endfunction

    // One access: sampled at the next rising edge, response visible #1 later
    task automatic acc(input logic wr, input logic [SET_BITS-1:0] set,
                       input logic [TAG_BITS+1:0] tg, input logic [LINE_BITS-1:0] dt);
        enable_i = 1'b1; write_i = wr; addr_i = set; tag_i = tg; data_i = dt;
        @(posedge clk); #1;
        enable_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({resp_o, hit_o, busy_o, wb_valid_o, flush_done_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 00000", {resp_o, hit_o, busy_o, wb_valid_o, flush_done_o}); end
        checks++; if (tag_o !== '0 || data_o !== '0) begin
            errors++; $display("FAIL reset_data: got tag %0h exp 0", tag_o); end
        rst_i = 1'b1;
        @(posedge clk); #1;
        acc(1'b0, 4'd3, ent(1'b1, 1'b0, 23'h12), '0);
        checks++; if (resp_o !== 1'b1 || hit_o !== 1'b0) begin
            errors++; $display("FAIL first_lookup: got resp %b hit %b exp resp 1 hit 0", resp_o, hit_o); end
        checks++; if (tag_o !== '0 || data_o !== '0) begin
            errors++; $display("FAIL first_victim: got tag %0h exp 0", tag_o); end
        @(posedge clk); #1;
        checks++; if (resp_o !== 1'b0) begin
            errors++; $display("FAIL resp_pulse: got %b exp 0", resp_o); end
    endtask

    task automatic test_lru();
        acc(1'b1, 4'd5, ent(1'b1, 1'b0, TA), line(32'hAAAA0001));
        checks++; if (hit_o !== 1'b0 || tag_o !== '0) begin
            errors++; $display("FAIL refill_a: got hit %b tag %0h exp hit 0 tag 0", hit_o, tag_o); end
        acc(1'b1, 4'd5, ent(1'b1, 1'b0, TB), line(32'hBBBB0002));
        acc(1'b1, 4'd5, ent(1'b1, 1'b0, TC), line(32'hCCCC0003));
        acc(1'b1, 4'd5, ent(1'b1, 1'b0, TD), line(32'hDDDD0004));
        checks++; if (hit_o !== 1'b0 || tag_o !== '0) begin
            errors++; $display("FAIL refill_d: got hit %b tag %0h exp hit 0 tag 0", hit_o, tag_o); end
        acc(1'b0, 5'd5, ent(1'b1, 1'b0, TA), '0);
        checks++; if (hit_o !== 1'b1 || tag_o !== ent(1'b1, 1'b0, TA) || data_o !== line(32'hAAAA0001)) begin
            errors++; $display("FAIL lookup_a: got hit %b tag %0h exp hit 1 tag %0h", hit_o, tag_o, ent(1'b1, 1'b0, TA)); end
        acc(1'b1, 4'd5, ent(1'b1, 1'b0, TE), line(32'hEEEE0005));
        checks++; if (hit_o !== 1'b0 || tag_o !== ent(1'b1, 1'b0, TB) || data_o !== line(32'hBBBB0002)) begin
            errors++; $display("FAIL evict_b: got hit %b tag %0h exp hit 0 tag %0h", hit_o, tag_o, ent(1'b1, 1'b0, TB)); end
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TB), '0);
        checks++; if (hit_o !== 1'b0) begin
            errors++; $display("FAIL b_gone: got hit %b exp 0", hit_o); end
    endtask

    task automatic test_write_hit();
        acc(1'b1, 4'd5, ent(1'b1, 1'b1, TC), line(32'hDEADBEEF));
        checks++; if (hit_o !== 1'b1 || tag_o !== ent(1'b1, 1'b1, TC) || data_o !== line(32'hDEADBEEF)) begin
            errors++; $display("FAIL write_hit: got hit %b tag %0h exp hit 1 tag %0h", hit_o, tag_o, ent(1'b1, 1'b1, TC)); end
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TC), '0);
        checks++; if (hit_o !== 1'b1 || tag_o[TAG_BITS] !== 1'b1 || data_o !== line(32'hDEADBEEF)) begin
            errors++; $display("FAIL read_dirty_c: got hit %b tag %0h exp hit 1 dirty C", hit_o, tag_o); end
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TD), '0);
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TA), '0);
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TE), '0);
        checks++; if (hit_o !== 1'b1 || data_o !== line(32'hEEEE0005)) begin
            errors++; $display("FAIL lookup_e: got hit %b exp 1", hit_o); end
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TF), '0);
        checks++; if (hit_o !== 1'b0 || tag_o !== ent(1'b1, 1'b1, TC) || data_o !== line(32'hDEADBEEF)) begin
            errors++; $display("FAIL dirty_victim: got hit %b tag %0h exp hit 0 tag %0h", hit_o, tag_o, ent(1'b1, 1'b1, TC)); end
    endtask

    task automatic test_flush();
        int cyc;
        int xfers;
        int dones;
        logic [SET_BITS-1:0] last_set;
        logic [TAG_BITS-1:0] last_tag;
        acc(1'b1, 4'd5, ent(1'b1, 1'b0, TC), line(32'hDEADBEEF));
        acc(1'b1, 4'd0, ent(1'b1, 1'b0, TX), line(32'h10001000));
        acc(1'b1, 4'd0, ent(1'b1, 1'b1, T1), line(32'h11111111));
        acc(1'b1, 4'd15, ent(1'b1, 1'b1, T2), line(32'h22222222));
        // Flush request and a lookup in the same cycle
        flush_req_i = 1'b1; flush_inv_i = 1'b1;
        enable_i = 1'b1; write_i = 1'b0; addr_i = 4'd15; tag_i = ent(1'b1, 1'b0, T2);
        @(posedge clk); #1;
        flush_req_i = 1'b0; flush_inv_i = 1'b0; enable_i = 1'b0;
        checks++; if (resp_o !== 1'b1 || hit_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++; $display("FAIL flush_cycle_access: got resp %b hit %b busy %b exp 1 1 1", resp_o, hit_o, busy_o); end
        cyc = 0;
        while (!wb_valid_o && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd0 || wb_tag_o !== T1 || wb_data_o !== line(32'h11111111)) begin
            errors++; $display("FAIL first_offer: got valid %b set %0d tag %0h exp 1 0 %0h", wb_valid_o, wb_set_o, wb_tag_o, T1); end
        enable_i = 1'b1; addr_i = 4'd0; tag_i = ent(1'b1, 1'b0, T1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd0 || wb_tag_o !== T1 || wb_data_o !== line(32'h11111111)) begin
                errors++; $display("FAIL offer_stable: got valid %b set %0d tag %0h exp 1 0 %0h", wb_valid_o, wb_set_o, wb_tag_o, T1); end
            checks++; if (resp_o !== 1'b0) begin
                errors++; $display("FAIL busy_no_resp: got %b exp 0", resp_o); end
        end
        enable_i = 1'b0;
        wb_ready_i = 1'b1;
        xfers = 0; dones = 0; last_set = '0; last_tag = '0; cyc = 0;
        while (cyc < 300) begin
            @(posedge clk); #1; cyc++;
            if (wb_valid_o) begin xfers++; last_set = wb_set_o; last_tag = wb_tag_o; end
            if (flush_done_o) dones++;
            if (!busy_o) break;
        end
        wb_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_end: got busy %b exp 0", busy_o); end
        checks++; if (xfers != 1 || last_set !== 4'd15 || last_tag !== T2) begin
            errors++; $display("FAIL second_xfer: got n %0d set %0d tag %0h exp 1 15 %0h", xfers, last_set, last_tag, T2); end
        checks++; if (dones != 1) begin
            errors++; $display("FAIL done_pulse: got %0d exp 1", dones); end
        acc(1'b0, 4'd0, ent(1'b1, 1'b0, T1), '0);
        checks++; if (hit_o !== 1'b0) begin
            errors++; $display("FAIL inv_set0: got hit %b exp 0", hit_o); end
        acc(1'b0, 4'd15, ent(1'b1, 1'b0, T2), '0);
        checks++; if (hit_o !== 1'b0) begin
            errors++; $display("FAIL inv_set15: got hit %b exp 0", hit_o); end
        acc(1'b0, 4'd5, ent(1'b1, 1'b0, TA), '0);
        checks++; if (hit_o !== 1'b0 || tag_o[TAG_BITS+1] !== 1'b0) begin
            errors++; $display("FAIL inv_set5: got hit %b tag %0h exp hit 0 invalid", hit_o, tag_o); end
    endtask

    task automatic test_reset_mid_flush();
        int cyc;
        int dones;
        acc(1'b1, 4'd2, ent(1'b1, 1'b1, T3), line(32'h33333333));
        flush_req_i = 1'b1; flush_inv_i = 1'b0;
        @(posedge clk); #1;
        flush_req_i = 1'b0;
        cyc = 0;
        while (!wb_valid_o && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd2) begin
            errors++; $display("FAIL emit_set2: got valid %b set %0d exp 1 2", wb_valid_o, wb_set_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if ({wb_valid_o, busy_o, flush_done_o} !== 3'b000) begin
            errors++; $display("FAIL abort_flags: got %b exp 000", {wb_valid_o, busy_o, flush_done_o}); end
        @(posedge clk); #1;
        rst_i = 1'b1;
        dones = 0;
        repeat (5) begin @(posedge clk); #1; if (flush_done_o) dones++; end
        checks++; if (dones != 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got dones %0d busy %b exp 0 0", dones, busy_o); end
        acc(1'b0, 4'd2, ent(1'b1, 1'b0, T3), '0);
        checks++; if (hit_o !== 1'b0 || tag_o !== '0) begin
            errors++; $display("FAIL abort_cleared: got hit %b tag %0h exp 0 0", hit_o, tag_o); end
    endtask

    initial begin
        test_reset();
        test_lru();
        test_write_hit();
        test_flush();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
